// File: rtl/r_fifo_pkt_if.sv
// AXI R-channel bundle shared by the write and read sides of r_fifo_pkt.
// The master drives the beat fields; the slave answers with RREADY.
interface r_fifo_pkt_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport slave (
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/r_fifo_pkt.sv
// Single-clock AXI R buffer, first-word-fall-through, any depth >= 2.
// Packet mode holds beats back until a whole burst is stored.
module r_fifo_pkt #(
  parameter int ID_WIDTH    = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int AF_THRESH   = 6,
  parameter int PACKET_MODE = 0,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  r_fifo_pkt_if.slave      s,
  r_fifo_pkt_if.master     m,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] burst_count,
  output logic             almost_full
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } beat_t;

  beat_t            mem [DEPTH];
  beat_t            head;
  beat_t            wbeat;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             esc;
  logic             full;
  logic             vld;
  logic             push;
  logic             pop;
  logic             push_last;
  logic             pop_last;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign s.RREADY  = ~full;
  assign push      = s.RVALID & ~full;
  assign wbeat     = '{s.RID, s.RDATA, s.RRESP, s.RLAST};
  assign head      = mem[rd_ptr];

  // Packet mode only releases stored bursts, or streams once escaped.
  assign vld = (count != '0) &
               ((PACKET_MODE == 0) | (burst_count != '0) | esc);

  assign pop       = vld & m.RREADY;
  assign push_last = push & s.RLAST;
  assign pop_last  = pop & head.last;

  assign m.RVALID = vld;
  assign m.RID    = vld ? head.id   : '0;
  assign m.RDATA  = vld ? head.data : '0;
  assign m.RRESP  = vld ? head.resp : '0;
  assign m.RLAST  = vld ? head.last : 1'b0;

  assign almost_full = (count >= CNT_W'(AF_THRESH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wbeat;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count       <= '0;
      burst_count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      unique case ({push_last, pop_last})
        2'b10:   burst_count <= burst_count + 1'b1;
        2'b01:   burst_count <= burst_count - 1'b1;
        default: burst_count <= burst_count;
      endcase
    end
  end

  // A full buffer with no complete burst would deadlock; stream it out.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      esc <= 1'b0;
    end else if ((PACKET_MODE != 0) && full && (burst_count == '0)) begin
      esc <= 1'b1;
    end else if (pop_last) begin
      esc <= 1'b0;
    end
  end

  a_cnt_max: assert property (@(posedge clk) disable iff (!nrst)
    count <= CNT_W'(DEPTH));
  a_burst_le: assert property (@(posedge clk) disable iff (!nrst)
    burst_count <= count);
  a_no_ovf: assert property (@(posedge clk) disable iff (!nrst)
    !(push && full));
  a_no_udf: assert property (@(posedge clk) disable iff (!nrst)
    !(pop && (count == '0)));

endmodule

// File: tb/tb_r_fifo_pkt.sv
// Bench for r_fifo_pkt: three configurations checked every cycle
// against a queue model, plus directed literal expectations.
module tb_r_fifo_pkt;

  localparam int IW = 4;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int DEP [N] = '{8, 5, 4};
  localparam int AFT [N] = '{6, 4, 3};
  localparam int PMD [N] = '{0, 0, 1};

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  beat_t [N-1:0]      in_beat;
  logic  [N-1:0]      in_valid;
  logic  [N-1:0]      in_rdy;
  beat_t [N-1:0]      o_beat;
  logic  [N-1:0]      o_sready;
  logic  [N-1:0]      o_valid;
  logic  [N-1:0]      o_af;
  logic  [N-1:0][3:0] o_cnt;
  logic  [N-1:0][3:0] o_bc;

  int tests = 0;
  int fails = 0;
  int rmode [N];

  beat_t txq [N][$];
  beat_t mq  [N][$];
  beat_t rx  [N][$];
  bit    esc [N];

  for (genvar g = 0; g < N; g++) begin : gd
    localparam int CW = $clog2(DEP[g] + 1);
    logic [CW-1:0] c;
    logic [CW-1:0] b;
    r_fifo_pkt_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) s_if ();
    r_fifo_pkt_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) m_if ();
    r_fifo_pkt #(
      .ID_WIDTH(IW), .DATA_WIDTH(DW), .DEPTH(DEP[g]),
      .AF_THRESH(AFT[g]), .PACKET_MODE(PMD[g])
    ) dut (
      .clk(clk), .nrst(nrst),
      .s(s_if.slave), .m(m_if.master),
      .count(c), .burst_count(b), .almost_full(o_af[g])
    );
    assign s_if.RID    = in_beat[g].id;
    assign s_if.RDATA  = in_beat[g].data;
    assign s_if.RRESP  = in_beat[g].resp;
    assign s_if.RLAST  = in_beat[g].last;
    assign s_if.RVALID = in_valid[g];
    assign m_if.RREADY = in_rdy[g];
    assign o_sready[g] = s_if.RREADY;
    assign o_valid[g]  = m_if.RVALID;
    assign o_beat[g]   = {m_if.RID, m_if.RDATA, m_if.RRESP, m_if.RLAST};
    assign o_cnt[g]    = 4'(c);
    assign o_bc[g]     = 4'(b);
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bursts(int d);
    int n = 0;
    foreach (mq[d][i]) if (mq[d][i].last) n++;
    return n;
  endfunction

  function automatic bit exp_valid(int d);
    return mq[d].size() != 0 &&
           (PMD[d] == 0 || bursts(d) != 0 || esc[d]);
  endfunction

  // Reference model: a queue per buffer, updated at each edge.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int d = 0; d < N; d++) begin
        mq[d].delete();
        esc[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < N; d++) begin
        bit psh, pp, pl;
        int sz;
        sz  = mq[d].size();
        psh = in_valid[d] && sz != DEP[d];
        pp  = exp_valid(d) && in_rdy[d];
        pl  = pp && mq[d][0].last;
        if (PMD[d] != 0 && sz == DEP[d] && bursts(d) == 0) esc[d] = 1'b1;
        else if (pl) esc[d] = 1'b0;
        if (pp) void'(mq[d].pop_front());
        if (psh) mq[d].push_back(in_beat[d]);
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      int sz;
      bit v;
      sz = mq[d].size();
      v  = exp_valid(d);
      chk($sformatf("d%0d_sready", d), 64'(o_sready[d]), 64'(sz != DEP[d]));
      chk($sformatf("d%0d_valid", d), 64'(o_valid[d]), 64'(v));
      chk($sformatf("d%0d_count", d), 64'(o_cnt[d]), 64'(sz));
      chk($sformatf("d%0d_bcount", d), 64'(o_bc[d]), 64'(bursts(d)));
      chk($sformatf("d%0d_afull", d), 64'(o_af[d]), 64'(sz >= AFT[d]));
      chk($sformatf("d%0d_head", d), 64'(o_beat[d]), v ? 64'(mq[d][0]) : 64'd0);
      if (nrst && o_valid[d] && in_rdy[d]) rx[d].push_back(o_beat[d]);
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < N; d++)
      if (nrst && in_valid[d] && o_sready[d]) void'(txq[d].pop_front());
    #1;
    for (int d = 0; d < N; d++) begin
      in_valid[d] = txq[d].size() != 0;
      in_beat[d]  = (txq[d].size() != 0) ? txq[d][0] : '0;
      in_rdy[d]   = (rmode[d] == 2) ? 1'($urandom_range(0, 1)) : (rmode[d] == 1);
    end
  end

  task automatic wait_tx(int d, int budget);
    int k = 0;
    while (txq[d].size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk($sformatf("tx_drain_d%0d", d), 64'(txq[d].size()), 64'd0);
  endtask

  task automatic wait_rx(int d, int n, int budget);
    int k = 0;
    while (rx[d].size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk($sformatf("rx_cnt_d%0d", d), 64'(rx[d].size()), 64'(n));
  endtask

  function automatic beat_t mk(int id, int data, bit last);
    beat_t b;
    b.id   = IW'(id);
    b.data = DW'(data);
    b.resp = 2'(data);
    b.last = last;
    return b;
  endfunction

  initial begin
    in_valid = '0;
    in_rdy   = '0;
    in_beat  = '0;
    for (int d = 0; d < N; d++) rmode[d] = 0;
    #2 nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // reset state
    @(negedge clk);
    chk("t1_sready", 64'(o_sready[0]), 64'd1);
    chk("t1_valid", 64'(o_valid[0]), 64'd0);
    chk("t1_count", 64'(o_cnt[0]), 64'd0);
    chk("t1_rdata", 64'(o_beat[0].data), 64'd0);

    // fill depth 8, then drain
    for (int i = 0; i < 8; i++) txq[0].push_back(mk(1, 'h10 + i, i == 7));
    wait_tx(0, 60);
    repeat (2) @(negedge clk);
    chk("t2_count", 64'(o_cnt[0]), 64'd8);
    chk("t2_sready", 64'(o_sready[0]), 64'd0);
    chk("t2_afull", 64'(o_af[0]), 64'd1);
    chk("t2_head", 64'(o_beat[0].data), 64'h10);
    rmode[0] = 1;
    wait_rx(0, 8, 60);
    for (int i = 0; i < rx[0].size(); i++)
      chk($sformatf("t2_rx%0d", i), 64'(rx[0][i].data), 64'(32'h10 + i));
    repeat (2) @(negedge clk);
    chk("t2_empty", 64'(o_cnt[0]), 64'd0);
    rmode[0] = 0;

    // depth 5 streaming across pointer wrap
    rmode[1] = 2;
    for (int i = 0; i < 23; i++)
      txq[1].push_back(mk(i % 16, 'h100 + i, (i % 4) == 3));
    wait_rx(1, 23, 600);
    for (int i = 0; i < rx[1].size(); i++)
      chk($sformatf("t3_rx%0d", i), 64'(rx[1][i].data), 64'(32'h100 + i));
    rmode[1] = 0;

    // packet mode: burst held until RLAST stored
    rmode[2] = 1;
    txq[2].push_back(mk(2, 'h200, 1'b0));
    txq[2].push_back(mk(2, 'h201, 1'b0));
    wait_tx(2, 20);
    repeat (2) @(negedge clk);
    chk("t4_held", 64'(o_valid[2]), 64'd0);
    chk("t4_count", 64'(o_cnt[2]), 64'd2);
    txq[2].push_back(mk(2, 'h202, 1'b1));
    wait_rx(2, 3, 20);
    for (int i = 0; i < rx[2].size(); i++) begin
      chk($sformatf("t4_id%0d", i), 64'(rx[2][i].id), 64'd2);
      chk($sformatf("t4_rx%0d", i), 64'(rx[2][i].data), 64'(32'h200 + i));
    end
    repeat (2) @(negedge clk);
    chk("t4_bcount", 64'(o_bc[2]), 64'd0);

    // packet mode: burst longer than depth escapes
    rx[2].delete();
    rmode[2] = 0;
    for (int i = 0; i < 6; i++) txq[2].push_back(mk(5, 'h300 + i, i == 5));
    repeat (8) @(negedge clk);
    chk("t5_full", 64'(o_cnt[2]), 64'd4);
    chk("t5_escape", 64'(o_valid[2]), 64'd1);
    rmode[2] = 1;
    wait_tx(2, 40);
    wait_rx(2, 6, 40);
    for (int i = 0; i < rx[2].size(); i++)
      chk($sformatf("t5_rx%0d", i), 64'(rx[2][i].data), 64'(32'h300 + i));
    txq[2].push_back(mk(6, 'h400, 1'b0));
    repeat (4) @(negedge clk);
    chk("t5_esc_clr", 64'(o_valid[2]), 64'd0);

    // reset mid-burst
    txq[2].push_back(mk(6, 'h401, 1'b0));
    txq[2].push_back(mk(6, 'h402, 1'b0));
    wait_tx(2, 20);
    @(negedge clk);
    chk("t6_pre", 64'(o_cnt[2]), 64'd3);
    @(posedge clk);
    #1 nrst = 1'b0;
    rx[2].delete();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    chk("t6_count", 64'(o_cnt[2]), 64'd0);
    chk("t6_valid", 64'(o_valid[2]), 64'd0);
    chk("t6_bcount", 64'(o_bc[2]), 64'd0);
    txq[2].push_back(mk(7, 'h555, 1'b1));
    wait_rx(2, 1, 20);
    if (rx[2].size() != 0)
      chk("t6_first", 64'(rx[2][0].data), 64'h555);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
